// File: rtl/vlsu_pkg.sv
`default_nettype none
// ============================================================================
// vlsu_pkg : shared encodings for the vector load/store address generator
// Revision : 1.0
// ============================================================================
package vlsu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000111;
  localparam logic [6:0] OPC_STORE = 7'b0100111;

  localparam logic [2:0] WIDTH_E8  = 3'b000;
  localparam logic [2:0] WIDTH_E16 = 3'b101;
  localparam logic [2:0] WIDTH_E32 = 3'b110;

  typedef logic [1:0] eew_t;

  localparam eew_t EEW_8  = 2'd0;
  localparam eew_t EEW_16 = 2'd1;
  localparam eew_t EEW_32 = 2'd2;

  typedef enum logic [1:0] {
    MOP_UNIT      = 2'b00,
    MOP_IDX_UNORD = 2'b01,
    MOP_STRIDED   = 2'b10,
    MOP_IDX_ORD   = 2'b11
  } mop_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Returns {legal, eew} for the instruction width field.
  function automatic logic [2:0] decode_width(input logic [2:0] width);
    logic [2:0] res;
    res = 3'b000;
    case (width)
      WIDTH_E8:  res = {1'b1, EEW_8};
      WIDTH_E16: res = {1'b1, EEW_16};
      WIDTH_E32: res = {1'b1, EEW_32};
      default:   res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vlsu_lane_addr.sv
`default_nettype none
// ============================================================================
// vlsu_lane_addr : one lane's address register, loaded at accept, stepped per beat
// Revision : 1.0
// ============================================================================
module vlsu_lane_addr
  import vlsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANE       = 0
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  init,
  input  logic                  step,
  input  logic                  strided,
  input  eew_t                  eew,
  input  logic [DATA_WIDTH-1:0] base,
  input  logic [DATA_WIDTH-1:0] stride,
  input  logic [DATA_WIDTH-1:0] step_amt,
  output logic [DATA_WIDTH-1:0] addr
);

  logic [DATA_WIDTH-1:0] lane_off;

  assign lane_off = strided ? DATA_WIDTH'(LANE) * stride
                            : DATA_WIDTH'(LANE) << eew;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      addr <= '0;
    end else if (init) begin
      addr <= base + lane_off;
    end else if (step) begin
      addr <= addr + step_amt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vlsu_addr_gen.sv
`default_nettype none
// ============================================================================
// vlsu_addr_gen : walks a vector load/store in LANES-wide beats of memory requests
// Revision : 1.0
// ============================================================================
module vlsu_addr_gen
  import vlsu_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int LANES           = 4,
  parameter int VL_WIDTH        = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        clk_i,
  input  logic                        resetn_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic [DATA_WIDTH-1:0]       cmd_instr_i,
  input  logic [DATA_WIDTH-1:0]       cmd_base_i,
  input  logic [DATA_WIDTH-1:0]       cmd_stride_i,
  input  logic [VL_WIDTH-1:0]         cmd_vl_i,
  output logic [VL_WIDTH-1:0]         idx_beat_o,
  input  logic [LANES*DATA_WIDTH-1:0] idx_offset_i,
  output logic                        req_valid_o,
  input  logic                        req_ready_i,
  output logic [LANES*DATA_WIDTH-1:0] req_addr_o,
  output logic [LANES-1:0]            req_lane_en_o,
  output logic                        req_we_o,
  output logic [1:0]                  req_eew_o,
  output logic [VL_WIDTH-1:0]         req_beat_o,
  input  logic                        rsp_valid_i,
  input  logic                        rsp_error_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        done_error_o
);

  localparam int LANE_BITS = $clog2(LANES);
  localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1);

  state_e                state;
  logic [VL_WIDTH-1:0]   beat;
  logic [VL_WIDTH-1:0]   last_beat;
  logic [VL_WIDTH-1:0]   vl_q;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      out_next;
  logic                  err;
  logic                  indexed_q;
  logic                  we_q;
  eew_t                  eew_q;
  logic [DATA_WIDTH-1:0] base_q;
  logic [DATA_WIDTH-1:0] step_q;

  logic [6:0]            opcode;
  logic [2:0]            wdec;
  mop_e                  mop;
  logic                  legal;
  eew_t                  dec_eew;
  logic                  dec_strided;
  logic                  dec_indexed;
  logic [DATA_WIDTH-1:0] dec_step;
  logic                  accept;
  logic                  fire;
  logic                  rsp_ok;
  logic                  unused_instr_bits;

  assign opcode      = cmd_instr_i[6:0];
  assign wdec        = decode_width(cmd_instr_i[14:12]);
  assign mop         = mop_e'(cmd_instr_i[27:26]);
  assign legal       = wdec[2] && (opcode == OPC_LOAD || opcode == OPC_STORE);
  assign dec_eew     = wdec[1:0];
  assign dec_strided = (mop == MOP_STRIDED);
  assign dec_indexed = (mop == MOP_IDX_UNORD) || (mop == MOP_IDX_ORD);
  assign dec_step    = dec_strided ? (cmd_stride_i << LANE_BITS)
                                   : (DATA_WIDTH'(LANES) << dec_eew);
  assign unused_instr_bits = ^{cmd_instr_i[DATA_WIDTH-1:28],
                               cmd_instr_i[25:15], cmd_instr_i[11:7]};

  assign accept      = cmd_valid_i && (state == ST_IDLE);
  assign req_valid_o = (state == ST_GEN) && (outstanding < CNT_W'(MAX_OUTSTANDING));
  assign fire        = req_valid_o && req_ready_i;
  assign rsp_ok      = rsp_valid_i && (outstanding != '0);

  assign cmd_ready_o  = (state == ST_IDLE);
  assign busy_o       = (state != ST_IDLE);
  assign done_o       = (state == ST_DONE);
  assign done_error_o = (state == ST_DONE) && err;
  assign req_we_o     = we_q;
  assign req_eew_o    = eew_q;
  assign req_beat_o   = beat;
  assign idx_beat_o   = beat;

  always_comb begin
    out_next = outstanding;
    if (fire && !rsp_ok) begin
      out_next = outstanding + CNT_W'(1);
    end else if (!fire && rsp_ok) begin
      out_next = outstanding - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      outstanding <= '0;
    end else begin
      outstanding <= out_next;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state     <= ST_IDLE;
      beat      <= '0;
      last_beat <= '0;
      vl_q      <= '0;
      err       <= 1'b0;
      indexed_q <= 1'b0;
      we_q      <= 1'b0;
      eew_q     <= EEW_8;
      base_q    <= '0;
      step_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            beat      <= '0;
            // ceil(vl/LANES)-1; only meaningful when vl != 0
            last_beat <= (cmd_vl_i - VL_WIDTH'(1)) >> LANE_BITS;
            vl_q      <= cmd_vl_i;
            err       <= !legal;
            indexed_q <= dec_indexed;
            we_q      <= (opcode == OPC_STORE);
            eew_q     <= dec_eew;
            base_q    <= cmd_base_i;
            step_q    <= dec_step;
            if (!legal || cmd_vl_i == '0) begin
              state <= ST_DONE;
            end else begin
              state <= ST_GEN;
            end
          end
        end
        ST_GEN: begin
          if (rsp_ok && rsp_error_i) begin
            err <= 1'b1;
          end
          if (fire) begin
            beat <= beat + VL_WIDTH'(1);
            if (beat == last_beat) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (rsp_ok && rsp_error_i) begin
            err <= 1'b1;
          end
          if (out_next == '0) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          err   <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [DATA_WIDTH-1:0] lane_addr;

      vlsu_lane_addr #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANE       (l)
      ) u_lane (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .init     (accept),
        .step     (fire),
        .strided  (dec_strided),
        .eew      (dec_eew),
        .base     (cmd_base_i),
        .stride   (cmd_stride_i),
        .step_amt (step_q),
        .addr     (lane_addr)
      );

      assign req_addr_o[l*DATA_WIDTH +: DATA_WIDTH] =
          indexed_q ? base_q + idx_offset_i[l*DATA_WIDTH +: DATA_WIDTH] : lane_addr;

      // Element index {beat, lane} against vl gives the tail mask.
      assign req_lane_en_o[l] = {beat, LANE_BITS'(l)} < {{LANE_BITS{1'b0}}, vl_q};
    end
  endgenerate

  a_no_spurious_rsp : assert property (@(posedge clk_i) disable iff (!resetn_i)
                                       !(rsp_valid_i && outstanding == '0));

endmodule

`default_nettype wire

// File: tb/tb_vlsu_addr_gen.sv
`default_nettype none
// ============================================================================
// tb_vlsu_addr_gen : random and directed commands checked against an element-level model
// Revision : 1.0
// ============================================================================
module tb_vlsu_addr_gen;

  logic         clk = 1'b0;
  logic         resetn;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [31:0]  cmd_instr;
  logic [31:0]  cmd_base;
  logic [31:0]  cmd_stride;
  logic [7:0]   cmd_vl;
  logic [7:0]   idx_beat;
  logic [127:0] idx_offset;
  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_addr;
  logic [3:0]   req_lane_en;
  logic         req_we;
  logic [1:0]   req_eew;
  logic [7:0]   req_beat;
  logic         rsp_valid;
  logic         rsp_error;
  logic         busy;
  logic         done;
  logic         done_error;

  int errors = 0;
  int checks = 0;

  logic [31:0] offs [64][4];
  bit          err_beat [64];

  always #5 clk = ~clk;

  vlsu_addr_gen #(
    .DATA_WIDTH      (32),
    .LANES           (4),
    .VL_WIDTH        (8),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk_i         (clk),
    .resetn_i      (resetn),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_instr_i   (cmd_instr),
    .cmd_base_i    (cmd_base),
    .cmd_stride_i  (cmd_stride),
    .cmd_vl_i      (cmd_vl),
    .idx_beat_o    (idx_beat),
    .idx_offset_i  (idx_offset),
    .req_valid_o   (req_valid),
    .req_ready_i   (req_ready),
    .req_addr_o    (req_addr),
    .req_lane_en_o (req_lane_en),
    .req_we_o      (req_we),
    .req_eew_o     (req_eew),
    .req_beat_o    (req_beat),
    .rsp_valid_i   (rsp_valid),
    .rsp_error_i   (rsp_error),
    .busy_o        (busy),
    .done_o        (done),
    .done_error_o  (done_error)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] opc, input logic [2:0] w,
                                           input logic [1:0] mop);
    logic [31:0] r;
    r = $urandom;
    return {r[31:28], mop, r[25:15], w, r[11:7], opc};
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_req_valid"}, req_valid, 0);
    check({tag, "_req_addr"}, req_addr, 0);
    check({tag, "_lane_en"}, req_lane_en, 0);
    check({tag, "_we"}, req_we, 0);
    check({tag, "_eew"}, req_eew, 0);
    check({tag, "_beat"}, req_beat, 0);
    check({tag, "_idx_beat"}, idx_beat, 0);
  endtask

  // One command end-to-end: accept, per-cycle request/response checking, done, return to idle.
  task automatic run_cmd(input logic [31:0] instr, input logic [31:0] base,
                         input logic [31:0] stride, input int vl, input int ready_pct,
                         input int stall, input int dmin, input int dmax,
                         input int err_pct, input int err_force);
    logic [6:0]   opc;
    logic [2:0]   w;
    logic [1:0]   mop;
    bit           legal;
    int           esize;
    int           eew;
    int           mode;
    int           nbeats;
    int           issued;
    int           outc;
    int           last_due;
    int           d;
    int           rb;
    bit           exp_done;
    bit           exp_err;
    bit           exp_valid;
    bit           seen_done;
    bit           rsp_now;
    logic [127:0] ea;
    logic [3:0]   em;
    logic [31:0]  a;
    int           due[$];
    int           bq[$];

    opc   = instr[6:0];
    w     = instr[14:12];
    mop   = instr[27:26];
    legal = (opc == 7'b0000111 || opc == 7'b0100111) &&
            (w == 3'b000 || w == 3'b101 || w == 3'b110);
    esize = (w == 3'b101) ? 2 : (w == 3'b110) ? 4 : 1;
    eew   = (w == 3'b101) ? 1 : (w == 3'b110) ? 2 : 0;
    mode  = (mop == 2'b00) ? 0 : (mop == 2'b10) ? 1 : 2;
    nbeats = (legal && vl > 0) ? (vl + 3) / 4 : 0;
    for (int b = 0; b < 64; b++) begin
      err_beat[b] = ($urandom_range(0, 99) < err_pct) || (b == err_force);
    end
    exp_err = !legal;

    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_instr  = instr;
    cmd_base   = base;
    cmd_stride = stride;
    cmd_vl     = 8'(vl);
    #1;
    check("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);

    issued = 0; outc = 0; last_due = 0; seen_done = 0;
    exp_done = (nbeats == 0);
    for (int cyc = 1; cyc <= 3000 && !seen_done; cyc++) begin
      @(negedge clk);
      cmd_valid  = ($urandom_range(0, 3) == 0);
      cmd_instr  = mk_instr(7'b0000111, 3'b110, 2'b00);
      cmd_vl     = 8'($urandom_range(1, 20));
      rsp_valid  = 1'b0;
      rsp_error  = 1'b0;
      rsp_now    = 0;
      if (due.size() > 0 && due[0] <= cyc) begin
        void'(due.pop_front());
        rb        = bq.pop_front();
        rsp_valid = 1'b1;
        rsp_error = err_beat[rb];
        if (err_beat[rb]) exp_err = 1;
        rsp_now   = 1;
      end
      req_ready = (cyc > stall) && ($urandom_range(0, 99) < ready_pct);
      for (int l = 0; l < 4; l++) idx_offset[l*32 +: 32] = offs[idx_beat[5:0]][l];
      #1;
      check("done", done, exp_done);
      if (done) begin
        check("done_error", done_error, exp_err);
        check("req_valid_in_done", req_valid, 0);
        check("beats_before_done", issued, nbeats);
        seen_done = 1;
        cmd_valid = 1'b0;
      end else begin
        check("busy", busy, 1);
        check("cmd_ready_busy", cmd_ready, 0);
        exp_valid = (issued < nbeats) && (outc < 4);
        check("req_valid", req_valid, exp_valid);
        if (req_valid && exp_valid) begin
          for (int l = 0; l < 4; l++) begin
            case (mode)
              0:       a = base + 32'((issued * 4 + l) * esize);
              1:       a = base + 32'(issued * 4 + l) * stride;
              default: a = base + offs[issued][l];
            endcase
            ea[l*32 +: 32] = a;
            em[l] = (issued * 4 + l) < vl;
          end
          check("req_addr", req_addr, ea);
          check("lane_en", req_lane_en, em);
          check("we", req_we, (opc == 7'b0100111));
          check("eew", req_eew, eew);
          check("req_beat", req_beat, issued);
          check("idx_beat", idx_beat, issued);
          if (req_ready) begin
            d = cyc + $urandom_range(dmin, dmax);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            due.push_back(d);
            bq.push_back(issued);
            issued++;
            outc++;
          end
        end
        if (rsp_now) outc--;
        exp_done = (issued == nbeats) && (outc == 0);
      end
    end
    if (!seen_done) check("done_timeout", 0, 1);
    rsp_valid = 1'b0;
    rsp_error = 1'b0;
    @(negedge clk);
    #1;
    check("idle_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
  endtask

  initial begin
    resetn     = 1'b0;
    cmd_valid  = 1'b0;
    cmd_instr  = '0;
    cmd_base   = '0;
    cmd_stride = '0;
    cmd_vl     = '0;
    idx_offset = '0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_error  = 1'b0;
    for (int b = 0; b < 64; b++)
      for (int l = 0; l < 4; l++) offs[b][l] = $urandom;

    repeat (3) @(negedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    resetn = 1'b1;

    // Unit e32 load, two beats with a 2-element tail
    run_cmd(mk_instr(7'b0000111, 3'b110, 2'b00), 32'h1000, 32'h0, 6, 100, 0, 2, 2, 0, -1);
    // Strided e8 store, single beat
    run_cmd(mk_instr(7'b0100111, 3'b000, 2'b10), 32'h200, 32'h20, 4, 100, 0, 2, 2, 0, -1);
    // Backpressure on beat 0 for three cycles
    run_cmd(mk_instr(7'b0000111, 3'b101, 2'b00), 32'h0, 32'h0, 8, 100, 3, 1, 3, 0, -1);
    // Outstanding limit: responses slow enough to saturate
    run_cmd(mk_instr(7'b0000111, 3'b110, 2'b00), 32'h8000, 32'h0, 32, 100, 0, 8, 10, 0, -1);
    // Indexed e32 with a negative offset
    offs[0][0] = 32'h10; offs[0][1] = 32'h0; offs[0][2] = 32'h8; offs[0][3] = 32'hFFFFFFFC;
    run_cmd(mk_instr(7'b0000111, 3'b110, 2'b01), 32'h4000, 32'h0, 4, 100, 0, 1, 2, 0, -1);
    // Illegal width and illegal opcode
    run_cmd(mk_instr(7'b0000111, 3'b011, 2'b00), 32'h100, 32'h0, 8, 100, 0, 1, 2, 0, -1);
    run_cmd(mk_instr(7'b0110011, 3'b110, 2'b00), 32'h100, 32'h0, 8, 100, 0, 1, 2, 0, -1);
    // Response error on beat 1 of three
    run_cmd(mk_instr(7'b0100111, 3'b110, 2'b00), 32'h3000, 32'h0, 12, 100, 0, 1, 3, 0, 1);
    // vl == 0 completes cleanly with no requests
    run_cmd(mk_instr(7'b0000111, 3'b000, 2'b00), 32'h500, 32'h0, 0, 100, 0, 1, 2, 0, -1);
    // Address wrap past 2^32
    run_cmd(mk_instr(7'b0000111, 3'b110, 2'b00), 32'hFFFFFFF8, 32'h0, 8, 100, 0, 1, 2, 0, -1);
    run_cmd(mk_instr(7'b0100111, 3'b101, 2'b10), 32'hFFFFFF00, 32'h80, 9, 80, 0, 1, 4, 0, -1);

    for (int n = 0; n < 40; n++) begin
      logic [6:0]  opc;
      logic [2:0]  w;
      logic [31:0] stride;
      int          sel;
      sel = $urandom_range(0, 9);
      opc = (sel == 0) ? 7'($urandom) : (sel < 5) ? 7'b0000111 : 7'b0100111;
      sel = $urandom_range(0, 9);
      w   = (sel == 0) ? 3'($urandom) : (sel < 4) ? 3'b000 : (sel < 7) ? 3'b101 : 3'b110;
      stride = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 64));
      for (int b = 0; b < 64; b++)
        for (int l = 0; l < 4; l++) offs[b][l] = $urandom;
      run_cmd(mk_instr(opc, w, 2'($urandom)), $urandom, stride,
              ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40),
              $urandom_range(40, 100), $urandom_range(0, 2), 1,
              $urandom_range(1, 8), $urandom_range(0, 10), -1);
    end

    // Reset in the middle of an instruction abandons it without done
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_instr  = mk_instr(7'b0000111, 3'b110, 2'b00);
    cmd_base   = 32'h7000;
    cmd_vl     = 8'd40;
    req_ready  = 1'b1;
    @(negedge clk);
    cmd_valid  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("midop_busy", busy, 1);
    resetn = 1'b0;
    #1;
    check_reset_state("midop_reset");
    @(negedge clk);
    resetn    = 1'b1;
    req_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("post_reset_no_done", done, 0);
    end
    run_cmd(mk_instr(7'b0000111, 3'b101, 2'b00), 32'h60, 32'h0, 5, 100, 0, 1, 2, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vlsu_addr_gen.md
Name: vlsu_addr_gen

Overview:
Parametrised vector load/store address generator. It accepts one decoded-at-entry vector memory instruction per command handshake and walks the full vector length in beats of LANES elements. Each beat issues one multi-lane memory request with a per-lane enable mask. It supports unit-stride, strided and indexed modes at element widths 8/16/32, tracks outstanding responses, and signals completion or error. It sits between the instruction queue / scalar operand path and the memory request FIFO.

Parameters:
DATA_WIDTH, 32, address and operand width
LANES, 4, elements per beat (power of two, >=2)
VL_WIDTH, 8, width of vector length and beat counters
MAX_OUTSTANDING, 4, maximum issued-but-unanswered beats

Ports:
clk_i  in  1  clock
resetn_i  in  1  reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when both high
cmd_instr_i  in  DATA_WIDTH  raw vector load/store instruction word
cmd_base_i  in  DATA_WIDTH  rs1 base address
cmd_stride_i  in  DATA_WIDTH  rs2 byte stride
cmd_vl_i  in  VL_WIDTH  vector length in elements
idx_beat_o  out  VL_WIDTH  beat index whose offsets are requested (indexed mode)
idx_offset_i  in  LANES*DATA_WIDTH  per-lane byte offsets for idx_beat_o, lane 0 in LSBs
req_valid_o  out  1  memory request valid
req_ready_i  in  1  memory request accepted
req_addr_o  out  LANES*DATA_WIDTH  per-lane byte addresses
req_lane_en_o  out  LANES  active lanes for this beat
req_we_o  out  1  1=store, 0=load
req_eew_o  out  2  element size log2 (0=8b, 1=16b, 2=32b)
req_beat_o  out  VL_WIDTH  beat index of current request
rsp_valid_i  in  1  one beat response returned
rsp_error_i  in  1  response error, qualified by rsp_valid_i
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle completion pulse
done_error_o  out  1  qualified by done_o: illegal command or any response error

Behaviour:
- Reset: resetn_i asynchronous, active-low; clock clk_i. All state, counters and lane registers clear to 0. State=IDLE. All outputs 0 except cmd_ready_o=1. Reset mid-operation abandons the instruction; no done_o is produced.
- Decode at accept: opcode [6:0] 0000111=load, 0100111=store; width [14:12] 000->eew 0, 101->1, 110->2; mop [27:26] 00 unit, 10 strided, 01/11 indexed. Any other opcode or width is illegal.
- FSM IDLE -> GEN on accept with legal command and vl!=0.
- FSM IDLE -> DONE on accept with illegal command (done_error_o=1) or vl==0 (done_error_o=0). No requests are issued in either case.
- FSM GEN -> DRAIN when the last beat fires (req_valid_o & req_ready_i).
- FSM DRAIN -> DONE when the outstanding count reaches 0.
- FSM DONE -> IDLE after 1 cycle; done_o=1 in DONE.
- cmd_ready_o = (state==IDLE).
- Beats = ceil(vl/LANES). Lane l of beat b is enabled iff b*LANES+l < vl.
- Unit mode: lane register init base+(l<<eew); step LANES<<eew per fired beat.
- Strided mode: lane register init base+l*stride; step LANES*stride per fired beat.
- Unit and strided req_addr_o come straight from the lane registers and stay stable while req_valid_o & !req_ready_i.
- Indexed mode: req_addr_o[l] = base_q + idx_offset_i[l], combinational. idx_beat_o = req_beat_o. The provider must hold offsets stable while idx_beat_o is unchanged.
- All address arithmetic is modulo 2^DATA_WIDTH; wrap is silent. Disabled lanes still output computed addresses.
- req_valid_o = (state==GEN) && (outstanding < MAX_OUTSTANDING). There is no combinational path from rsp_valid_i.
- Outstanding counter: +1 on request fire, -1 on rsp_valid_i. A simultaneous fire and response leaves it unchanged.
- rsp_valid_i while the count is 0 is ignored (assertion flags it).
- Error flag is sticky from any rsp_error_i, or from an illegal decode, until DONE. A response error does not abort issue; remaining beats still issue.
- cmd_valid_i while busy is ignored (no accept).
- req_we_o, req_eew_o and base_q are latched at accept and held until IDLE.

Decomposition:
- Package vlsu_pkg: opcode constants, width-field encodings, mop enum, eew type, FSM state enum.
- Sub-module vlsu_lane_addr: per-lane address register with init/step load and eew/stride/lane-offset inputs, generated LANES times. Top level holds the FSM, beat counter, outstanding counter, tail mask and decode.

Test Plan:
- Unit e32 load, base 0x1000, vl=6, LANES=4, req_ready=1, responses 2 cycles later -> beat0 0x1000/04/08/0C en 1111, beat1 0x1010/14/18/1C en 0011, req_we_o=0, done_o with done_error_o=0 after 2nd response.
- Strided e8 store, base 0x200, stride 0x20, vl=4 -> single beat 0x200/220/240/260 en 1111, req_we_o=1, req_eew_o=0.
- Backpressure: unit e16, base 0x0, vl=8, req_ready_i low 3 cycles on beat0 -> addrs 0x0/2/4/6 held stable; beat1 0x8/A/C/E follows.
- Outstanding limit: vl=32, MAX_OUTSTANDING=4, no responses -> exactly 4 beats fire then req_valid_o=0; one response -> beat 4 issues next cycle; done after 8 responses.
- Indexed e32, base 0x4000, offsets {0x10,0x0,0x8,0xFFFFFFFC} -> addrs 0x4010/4000/4008/3FFC.
- Illegal width 3'b011 -> accepted, done_o=1 and done_error_o=1 one cycle later, no req_valid_o. rsp_error_i on beat1 of a 3-beat op -> all beats issue, done_error_o=1.
